// File: rtl/ibex_lsu_ctrl.sv
// Load/store unit control: drives the data bus, splits misaligned accesses
// into two word transactions and returns aligned, extended load data to ID.
module ibex_lsu_ctrl #(
    parameter bit SPLIT_ERR_ABORT = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        data_req_ex_i,
    input  logic        data_we_ex_i,
    input  logic [1:0]  data_type_ex_i,
    input  logic        data_sign_ext_ex_i,
    input  logic [31:0] data_wdata_ex_i,
    input  logic [31:0] adder_result_ex_i,
    output logic        addr_incr_req_o,
    output logic [31:0] addr_last_o,
    output logic        data_valid_o,
    output logic [31:0] rdata_o,
    output logic        load_err_o,
    output logic        store_err_o,
    output logic        busy_o,
    output logic        data_req_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic        data_err_i,
    output logic [31:0] data_addr_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    input  logic [31:0] data_rdata_i
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_GNT_MIS,
        WAIT_RVALID_MIS,
        WAIT_GNT,
        WAIT_RVALID
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_last_q, addr_last_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        split_q, split_d;

    logic        req;
    logic        incr;
    logic        valid;
    logic [1:0]  off_first;
    logic [1:0]  off_last;
    logic [1:0]  off_bus;
    logic        split_req;
    logic [3:0]  be;
    logic [63:0] wrot;
    logic [31:0] rlo;
    logic [63:0] rcat;
    logic [31:0] rext;

    assign off_first = adder_result_ex_i[1:0];
    assign off_last  = addr_last_q[1:0];
    // second part keeps the offset of the first granted address
    assign off_bus   = incr ? off_last : off_first;

    assign split_req = ((data_type_ex_i == 2'b00) && (off_first != 2'b00)) ||
                       ((data_type_ex_i == 2'b01) && (off_first == 2'b11));

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        split_d = split_q;
        rdata_d = rdata_q;
        req     = 1'b0;
        incr    = 1'b0;
        valid   = 1'b0;
        unique case (state_q)
            IDLE: begin
                err_d   = 1'b0;
                split_d = 1'b0;
                req     = data_req_ex_i;
                if (data_req_ex_i) begin
                    if (split_req) begin
                        state_d = data_gnt_i ? WAIT_RVALID_MIS : WAIT_GNT_MIS;
                    end else begin
                        state_d = data_gnt_i ? WAIT_RVALID : WAIT_GNT;
                    end
                end
            end
            WAIT_GNT_MIS: begin
                req = 1'b1;
                if (data_gnt_i) begin
                    state_d = WAIT_RVALID_MIS;
                end
            end
            WAIT_RVALID_MIS: begin
                if (data_rvalid_i) begin
                    rdata_d = data_rdata_i;
                    err_d   = err_q | data_err_i;
                    if (SPLIT_ERR_ABORT && data_err_i) begin
                        valid   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        req     = 1'b1;
                        incr    = 1'b1;
                        split_d = 1'b1;
                        state_d = data_gnt_i ? WAIT_RVALID : WAIT_GNT;
                    end
                end
            end
            WAIT_GNT: begin
                req  = 1'b1;
                incr = split_q;
                if (data_gnt_i) begin
                    state_d = WAIT_RVALID;
                end
            end
            WAIT_RVALID: begin
                if (data_rvalid_i) begin
                    valid   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        be = 4'b0000;
        if (incr) begin
            be = (data_type_ex_i == 2'b00) ?
                 (4'hF >> (3'd4 - {1'b0, off_last})) : 4'b0001;
        end else begin
            unique case (data_type_ex_i)
                2'b00: be = 4'hF << off_first;
                2'b01: begin
                    unique case (off_first)
                        2'd0: be = 4'b0011;
                        2'd1: be = 4'b0110;
                        2'd2: be = 4'b1100;
                        default: be = 4'b1000;
                    endcase
                end
                default: be = 4'b0001 << off_first;
            endcase
        end
    end

    assign wrot = {data_wdata_ex_i, data_wdata_ex_i} << {off_bus, 3'b000};

    assign addr_last_d = (data_req_o && data_gnt_i) ?
                         adder_result_ex_i : addr_last_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            addr_last_q <= 32'h0;
            rdata_q     <= 32'h0;
            err_q       <= 1'b0;
            split_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_last_q <= addr_last_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            split_q     <= split_d;
        end
    end

    // first word sits below the second in the concatenation
    assign rlo  = split_q ? rdata_q : data_rdata_i;
    assign rcat = {data_rdata_i, rlo} >> {off_last, 3'b000};

    always_comb begin
        unique case (data_type_ex_i)
            2'b00: rext = rcat[31:0];
            2'b01: rext = {{16{data_sign_ext_ex_i & rcat[15]}}, rcat[15:0]};
            default: rext = {{24{data_sign_ext_ex_i & rcat[7]}}, rcat[7:0]};
        endcase
    end

    assign data_req_o      = req & rst_ni;
    assign data_addr_o     = data_req_o ? {adder_result_ex_i[31:2], 2'b00} : 32'h0;
    assign data_we_o       = data_req_o & data_we_ex_i;
    assign data_be_o       = data_req_o ? be : 4'b0000;
    assign data_wdata_o    = data_req_o ? wrot[63:32] : 32'h0;
    assign addr_incr_req_o = data_req_o & incr;
    assign addr_last_o     = addr_last_q;
    assign data_valid_o    = valid;
    assign rdata_o         = valid ? rext : 32'h0;
    assign load_err_o      = valid & (err_q | data_err_i) & ~data_we_ex_i;
    assign store_err_o     = valid & (err_q | data_err_i) & data_we_ex_i;
    assign busy_o          = (state_q != IDLE);

endmodule

// File: tb/tb_ibex_lsu_ctrl.sv
// Scoreboard bench for ibex_lsu_ctrl: two instances (split abort off/on)
// share one bus responder; a negedge monitor checks bus beats and completions.
module tb_ibex_lsu_ctrl;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        logic        incr;
    } bus_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        chk;
        logic        lerr;
        logic        serr;
    } cpl_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we_ex = 1'b0;
    logic [1:0]  typ_ex = 2'b00;
    logic        sign_ex = 1'b0;
    logic [31:0] wdata_ex = 32'h0;
    logic [31:0] addr_ex = 32'h0;
    logic        gnt = 1'b0;
    logic        rvalid = 1'b0;
    logic        err = 1'b0;
    logic [31:0] rdata = 32'h0;

    logic        req_ex[2];
    logic        incr[2], valid[2], lerr[2], serr[2], busy[2];
    logic        breq[2], bwe[2];
    logic [31:0] last[2], rdo[2], baddr[2], bwd[2], adder[2];
    logic [3:0]  bbe[2];

    bus_t        bq[2][$];
    cpl_t        cq[2][$];
    logic [31:0] rq[$];
    logic        eq[$];

    int  checks = 0;
    int  errors = 0;
    int  gdly = 0;
    int  wcnt = 0;
    bit  pend = 1'b0;
    bit  hold = 1'b0;
    bit  g_n = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        assign adder[g] = incr[g] ? last[g] + 32'd4 : addr_ex;
        ibex_lsu_ctrl #(.SPLIT_ERR_ABORT(g == 1)) u_dut (
            .clk_i             (clk),
            .rst_ni            (rst_n),
            .data_req_ex_i     (req_ex[g]),
            .data_we_ex_i      (we_ex),
            .data_type_ex_i    (typ_ex),
            .data_sign_ext_ex_i(sign_ex),
            .data_wdata_ex_i   (wdata_ex),
            .adder_result_ex_i (adder[g]),
            .addr_incr_req_o   (incr[g]),
            .addr_last_o       (last[g]),
            .data_valid_o      (valid[g]),
            .rdata_o           (rdo[g]),
            .load_err_o        (lerr[g]),
            .store_err_o       (serr[g]),
            .busy_o            (busy[g]),
            .data_req_o        (breq[g]),
            .data_gnt_i        (gnt),
            .data_rvalid_i     (rvalid),
            .data_err_i        (err),
            .data_addr_o       (baddr[g]),
            .data_we_o         (bwe[g]),
            .data_be_o         (bbe[g]),
            .data_wdata_o      (bwd[g]),
            .data_rdata_i      (rdata)
        );
    end

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endfunction

    task automatic mon(input int d);
        bus_t e;
        cpl_t c;
        if (breq[d]) begin
            if (bq[d].size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexp_req%0d act=%h exp=none", d, baddr[d]);
            end else begin
                e = bq[d][0];
                chk($sformatf("addr%0d", d), baddr[d], e.addr);
                chk($sformatf("be%0d", d), {28'h0, bbe[d]}, {28'h0, e.be});
                chk($sformatf("we%0d", d), {31'h0, bwe[d]}, {31'h0, e.we});
                chk($sformatf("wdata%0d", d), bwd[d], e.wdata);
                chk($sformatf("incr%0d", d), {31'h0, incr[d]}, {31'h0, e.incr});
                if (gnt) void'(bq[d].pop_front());
            end
        end
        if (valid[d]) begin
            if (cq[d].size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexp_valid%0d act=1 exp=0", d);
            end else begin
                c = cq[d].pop_front();
                if (c.chk) chk($sformatf("rdata%0d", d), rdo[d], c.rdata);
                chk($sformatf("lerr%0d", d), {31'h0, lerr[d]}, {31'h0, c.lerr});
                chk($sformatf("serr%0d", d), {31'h0, serr[d]}, {31'h0, c.serr});
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
        g_n = (breq[0] | breq[1]) & gnt;
    end

    // bus responder: rvalid the cycle after a grant, grant after gdly waits
    always @(posedge clk) begin
        #1;
        if (pend && !hold) begin
            rvalid = 1'b1;
            rdata  = 32'h0;
            err    = 1'b0;
            if (rq.size() != 0) rdata = rq.pop_front();
            if (eq.size() != 0) err = eq.pop_front();
            pend = 1'b0;
        end else begin
            rvalid = 1'b0;
            err    = 1'b0;
        end
        if (g_n) pend = 1'b1;
        #1;
        if (breq[0] | breq[1]) begin
            if (wcnt >= gdly) begin
                gnt  = 1'b1;
                wcnt = 0;
            end else begin
                gnt  = 1'b0;
                wcnt++;
            end
        end else begin
            gnt  = 1'b0;
            wcnt = 0;
        end
    end

    task automatic eb(input int d, input logic [31:0] a, input logic [3:0] be,
                      input logic w, input logic [31:0] wd, input logic inc);
        bus_t e;
        e = '{addr: a, be: be, we: w, wdata: wd, incr: inc};
        bq[d].push_back(e);
    endtask

    task automatic ec(input int d, input logic [31:0] r, input logic c,
                      input logic le, input logic se);
        cpl_t e;
        e = '{rdata: r, chk: c, lerr: le, serr: se};
        cq[d].push_back(e);
    endtask

    task automatic resp(input logic [31:0] r, input logic e);
        rq.push_back(r);
        eq.push_back(e);
    endtask

    task automatic run(input int d, input logic w, input logic [1:0] t,
                       input logic s, input logic [31:0] a,
                       input logic [31:0] wd, input int dly);
        int n;
        @(posedge clk);
        #1;
        we_ex = w;
        typ_ex = t;
        sign_ex = s;
        addr_ex = a;
        wdata_ex = wd;
        gdly = dly;
        req_ex[d] = 1'b1;
        n = 0;
        while (!busy[d] && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        req_ex[d] = 1'b0;
        n = 0;
        while ((cq[d].size() != 0 || bq[d].size() != 0) && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL timeout%0d act=%0d exp=0", d, cq[d].size());
            cq[d].delete();
            bq[d].delete();
        end
        @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=running exp=done");
        $fatal(1);
    end

    initial begin
        req_ex[0] = 1'b1;
        req_ex[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", {31'h0, breq[0]}, 32'h0);
        chk("rst_busy", {31'h0, busy[0]}, 32'h0);
        chk("rst_valid", {31'h0, valid[0]}, 32'h0);
        chk("rst_last", last[0], 32'h0);
        chk("rst_rdata", rdo[0], 32'h0);
        req_ex[0] = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // LW aligned
        eb(0, 32'h1000, 4'b1111, 1'b0, 32'h0, 1'b0);
        ec(0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0);
        resp(32'hDEADBEEF, 1'b0);
        run(0, 1'b0, 2'b00, 1'b0, 32'h1000, 32'h0, 0);

        // LW misaligned by 2
        eb(0, 32'h1000, 4'b1100, 1'b0, 32'h0, 1'b0);
        eb(0, 32'h1004, 4'b0011, 1'b0, 32'h0, 1'b1);
        ec(0, 32'h3344AABB, 1'b1, 1'b0, 1'b0);
        resp(32'hAABBCCDD, 1'b0);
        resp(32'h11223344, 1'b0);
        run(0, 1'b0, 2'b00, 1'b0, 32'h1002, 32'h0, 0);

        // LH signed crossing word
        eb(0, 32'h2000, 4'b1000, 1'b0, 32'h0, 1'b0);
        eb(0, 32'h2004, 4'b0001, 1'b0, 32'h0, 1'b1);
        ec(0, 32'hFFFFFF80, 1'b1, 1'b0, 1'b0);
        resp(32'h80000000, 1'b0);
        resp(32'h000000FF, 1'b0);
        run(0, 1'b0, 2'b01, 1'b1, 32'h2003, 32'h0, 0);

        // SB with delayed grant
        eb(0, 32'h3000, 4'b0010, 1'b1, 32'h0000A500, 1'b0);
        ec(0, 32'h0, 1'b0, 1'b0, 1'b0);
        resp(32'h0, 1'b0);
        run(0, 1'b1, 2'b10, 1'b0, 32'h3001, 32'h000000A5, 3);

        // LW split, error on first part, no abort
        eb(0, 32'h1000, 4'b1110, 1'b0, 32'h0, 1'b0);
        eb(0, 32'h1004, 4'b0001, 1'b0, 32'h0, 1'b1);
        ec(0, 32'h0, 1'b0, 1'b1, 1'b0);
        resp(32'h12345678, 1'b1);
        resp(32'h9ABCDEF0, 1'b0);
        run(0, 1'b0, 2'b00, 1'b0, 32'h1001, 32'h0, 0);

        // same access on the aborting instance
        eb(1, 32'h1000, 4'b1110, 1'b0, 32'h0, 1'b0);
        ec(1, 32'h0, 1'b0, 1'b1, 1'b0);
        resp(32'h12345678, 1'b1);
        run(1, 1'b0, 2'b00, 1'b0, 32'h1001, 32'h0, 0);

        // SW split, error on second part, grant delayed
        eb(0, 32'h4000, 4'b1100, 1'b1, 32'h33441122, 1'b0);
        eb(0, 32'h4004, 4'b0011, 1'b1, 32'h33441122, 1'b1);
        ec(0, 32'h0, 1'b0, 1'b0, 1'b1);
        resp(32'h0, 1'b0);
        resp(32'h0, 1'b1);
        run(0, 1'b1, 2'b00, 1'b0, 32'h4002, 32'h11223344, 1);

        // byte and half extensions
        eb(0, 32'h5000, 4'b1000, 1'b0, 32'h0, 1'b0);
        ec(0, 32'h0000009A, 1'b1, 1'b0, 1'b0);
        resp(32'h9A000000, 1'b0);
        run(0, 1'b0, 2'b10, 1'b0, 32'h5003, 32'h0, 0);

        eb(0, 32'h5000, 4'b1000, 1'b0, 32'h0, 1'b0);
        ec(0, 32'hFFFFFF9A, 1'b1, 1'b0, 1'b0);
        resp(32'h9A000000, 1'b0);
        run(0, 1'b0, 2'b11, 1'b1, 32'h5003, 32'h0, 2);

        eb(0, 32'h6000, 4'b1100, 1'b0, 32'h0, 1'b0);
        ec(0, 32'h0000BEEF, 1'b1, 1'b0, 1'b0);
        resp(32'hBEEF1234, 1'b0);
        run(0, 1'b0, 2'b01, 1'b0, 32'h6002, 32'h0, 0);

        // reset while waiting for first-part rvalid; late rvalid must be ignored
        hold = 1'b1;
        gdly = 0;
        eb(0, 32'h1000, 4'b1100, 1'b0, 32'h0, 1'b0);
        resp(32'h55555555, 1'b0);
        @(posedge clk);
        #1;
        we_ex = 1'b0;
        typ_ex = 2'b00;
        sign_ex = 1'b0;
        addr_ex = 32'h1002;
        req_ex[0] = 1'b1;
        @(posedge clk);
        #1;
        req_ex[0] = 1'b0;
        chk("mid_busy", {31'h0, busy[0]}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req", {31'h0, breq[0]}, 32'h0);
        chk("mid_rst_busy", {31'h0, busy[0]}, 32'h0);
        chk("mid_rst_last", last[0], 32'h0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        hold = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("late_busy", {31'h0, busy[0]}, 32'h0);
        chk("late_pend", {31'h0, pend}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
